// File: rtl/serial_sub32_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master drives the request side; the slave (the subtractor) returns results and status.
interface serial_sub32_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             V;
    logic             Z;
    logic             busy;
    logic             done;

    modport master (
        output start, A, B, Bin,
        input  D, Bout, V, Z, busy, done
    );

    modport slave (
        input  start, A, B, Bin,
        output D, Bout, V, Z, busy, done
    );
endinterface

// File: rtl/serial_sub32.sv
// Bit-serial subtractor D = A - B - Bin: one full-subtractor bit per clock, LSB first.
// Results and flags are registered at the end of the run and held until the next run completes.
module serial_sub32 #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    serial_sub32_if.slave   bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr, b_sr, res;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             a_msb, b_msb;
    logic [WIDTH-1:0] d_q;
    logic             bout_q, v_q, z_q;

    logic             d_bit, br_next, last;
    logic [WIDTH-1:0] res_next;

    assign d_bit    = a_sr[0] ^ b_sr[0] ^ br;
    assign br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    assign res_next = {d_bit, res[WIDTH-1:1]};
    assign last     = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res    <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            d_q    <= '0;
            bout_q <= 1'b0;
            v_q    <= 1'b0;
            z_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_sr  <= bus.A;
                        b_sr  <= bus.B;
                        br    <= bus.Bin;
                        a_msb <= bus.A[WIDTH-1];
                        b_msb <= bus.B[WIDTH-1];
                        res   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    br   <= br_next;
                    res  <= res_next;
                    cnt  <= cnt + CW'(1);
                    // The final bit is still combinational here, so flags use res_next/d_bit.
                    if (last) begin
                        d_q    <= res_next;
                        bout_q <= br_next;
                        v_q    <= (a_msb != b_msb) & (d_bit != a_msb);
                        z_q    <= (res_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.D    = d_q;
    assign bus.Bout = bout_q;
    assign bus.V    = v_q;
    assign bus.Z    = z_q;
    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
endmodule

// File: tb/tb_serial_sub32.sv
// Directed bench for serial_sub32: arithmetic vectors, handshake timing, and mid-run reset.
module tb_serial_sub32;
    localparam int WIDTH = 32;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    serial_sub32_if #(.WIDTH(WIDTH)) bus ();

    serial_sub32 #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start one operation at the next rising edge (edge 0) and follow it through edge WIDTH+1.
    // With hs set, extra start pulses land on edges 5 and WIDTH with different operands.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic bin, input bit hs, input logic [31:0] ed,
                          input logic eb, input logic ev, input logic ez);
        int          busy_cyc;
        int          n_done;
        int          done_edge;
        bit          overlap;
        bit          moved;
        logic [31:0] d_prev;
        busy_cyc  = 0;
        n_done    = 0;
        done_edge = -1;
        overlap   = 0;
        moved     = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.Bin   = bin;
        @(posedge clk);
        #1;
        d_prev    = bus.D;
        bus.start = 1'b0;
        bus.A     = 32'hFFFF0000;
        bus.B     = 32'h0000FFFF;
        bus.Bin   = ~bin;
        if (bus.busy) busy_cyc++;
        for (int k = 1; k <= WIDTH + 1; k++) begin
            @(posedge clk);
            #1;
            if (bus.busy) busy_cyc++;
            if (bus.done) begin
                n_done++;
                done_edge = k;
            end
            if (bus.busy && bus.done) overlap = 1;
            if (k < WIDTH && bus.D !== d_prev) moved = 1;
            if (hs && (k == 4 || k == WIDTH - 1)) begin
                bus.start = 1'b1;
                bus.A     = ~a;
                bus.B     = a;
                bus.Bin   = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
        end
        chk({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(WIDTH));
        chk({tag, "_done_edge"}, 64'(done_edge), 64'(WIDTH));
        chk({tag, "_done_count"}, 64'(n_done), 64'd1);
        chk({tag, "_busy_done_overlap"}, 64'(overlap), 64'd0);
        chk({tag, "_held_during_run"}, 64'(moved), 64'd0);
        chk({tag, "_D"}, 64'(bus.D), 64'(ed));
        chk({tag, "_Bout"}, 64'(bus.Bout), 64'(eb));
        chk({tag, "_V"}, 64'(bus.V), 64'(ev));
        chk({tag, "_Z"}, 64'(bus.Z), 64'(ez));
    endtask

    initial begin
        int n_done;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Bin   = 1'b0;
        #12;
        chk("rst_D", 64'(bus.D), 64'd0);
        chk("rst_flags", {60'd0, bus.Bout, bus.V, bus.Z, bus.busy}, 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("basic",   32'd100,        32'd58,         1'b0, 0, 32'd42,         1'b0, 1'b0, 1'b0);
        run_op("under",   32'd0,          32'd1,          1'b0, 0, 32'hFFFFFFFF,   1'b1, 1'b0, 1'b0);
        run_op("ovf_neg", 32'h80000000,   32'd1,          1'b0, 0, 32'h7FFFFFFF,   1'b0, 1'b1, 1'b0);
        run_op("ovf_pos", 32'h7FFFFFFF,   32'hFFFFFFFF,   1'b0, 0, 32'h80000000,   1'b1, 1'b1, 1'b0);
        run_op("zero",    32'h12345678,   32'h12345678,   1'b0, 0, 32'd0,          1'b0, 1'b0, 1'b1);
        run_op("bin",     32'd10,         32'd3,          1'b1, 0, 32'd6,          1'b0, 1'b0, 1'b0);
        run_op("hs",      32'd1000,       32'd1,          1'b0, 1, 32'd999,        1'b0, 1'b0, 1'b0);
        // Starts at the earliest legal edge (WIDTH+2) right after the handshake run.
        run_op("next",    32'd1,          32'h80000000,   1'b0, 0, 32'h80000001,   1'b1, 1'b1, 1'b0);

        // Abort a run with an asynchronous reset between edges 10 and 11.
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 32'h55;
        bus.B     = 32'h11;
        bus.Bin   = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("abort_D", 64'(bus.D), 64'd0);
        chk("abort_flags", {60'd0, bus.Bout, bus.V, bus.Z, bus.busy}, 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        n_done = 0;
        for (int k = 0; k < WIDTH + 8; k++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) n_done++;
        end
        chk("abort_no_done", 64'(n_done), 64'd0);
        run_op("post_rst", 32'hDEADBEEF, 32'h0EADBEEF, 1'b0, 0, 32'hD0000000, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
